mux_pipe_nto1: RTL and testbench
================================

MUX_PIPE_NTO1 -- requirements
Module: mux_pipe_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bit width per channel (1..64).
REQ-002 SHALL have parameter NUM_IN, default 32, channel count (2..64, need not be a power of 2).
REQ-003 SHALL derive localparams: SELW = ceil(log2(NUM_IN)); LAT = ceil(SELW/2), the number of 4:1 register levels.
REQ-004 SHALL have port: clock  in  1  single clock, rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_data  in  NUM_IN*WIDTH  flattened channels; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port: in_sel  in  SELW  channel select.
REQ-008 SHALL have port: in_valid  in  1  in_data/in_sel are valid this cycle.
REQ-009 SHALL have port: in_ready  out  1  block accepts this cycle.
REQ-010 SHALL have port: out_data  out  WIDTH  selected channel.
REQ-011 SHALL have port: out_sel  out  SELW  select value that produced out_data.
REQ-012 SHALL have port: out_valid  out  1  out_data/out_sel valid.
REQ-013 SHALL have port: out_ready  in  1  downstream accepts this cycle.

Function
REQ-014 SHALL perform a transfer on any edge where valid and ready are both high, on the input side and on the output side independently.
REQ-015 SHALL implement a tree of 4:1 reductions; level k uses select bits [2k+1:2k]; the last level uses 1 bit when SELW is odd.
REQ-016 SHALL register the result of every level together with a per-level valid bit and the full select; latency is exactly LAT cycles from input transfer to out_valid with out_ready held high.
REQ-017 SHALL advance level k when level k is empty or level k+1 advances; output level advances when out_ready high or out_valid low.
REQ-018 SHALL drive in_ready combinationally as the advance condition of level 0; a full pipe under stall SHALL hold LAT items with no loss or duplication.
REQ-019 SHALL collapse bubbles: an empty level accepts data even while downstream is stalled.
REQ-020 SHALL return all-zero out_data for in_sel >= NUM_IN (unpopulated tree leaves tie to 0).
REQ-021 SHALL sustain throughput of one transfer per cycle with out_ready continuously high.
REQ-022 SHALL hold out_data/out_sel stable while out_valid high and out_ready low.
REQ-023 SHALL ignore in_data and in_sel when in_valid is low (no level captures; valids stay low).

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear all level valids, out_valid=0, out_data=0, out_sel=0.
REQ-025 SHALL drop in-flight items on reset asserted mid-operation; none reappear after release.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset_n deasserts.

Configuration
REQ-027 SHALL, when macro MUX_PIPE_SEL_ERR_EN is defined, add output port sel_err (out, 1): high with out_valid when that item's select was >= NUM_IN, and 0 when out_valid is low; reset value 0.
REQ-028 SHALL, when MUX_PIPE_SEL_ERR_EN is undefined, have no sel_err port and no associated storage; all other behaviour is identical.

Verification
REQ-029 SHALL cover: NUM_IN=32, WIDTH=32, channel i = 32'hA000_0000+i, in_sel=5, in_valid=1, out_ready=1 -> out_valid rises 3 cycles later with out_data=32'hA000_0005, out_sel=5.
REQ-030 SHALL cover: stream in_sel 0..31 back-to-back with out_ready=1 -> 32 consecutive out_valid cycles, out_data=A000_0000+n in order.
REQ-031 SHALL cover: out_ready=0 for 10 cycles while streaming -> exactly 3 items held, in_ready=0 after pipe fills, no loss or duplication after out_ready returns to 1.
REQ-032 SHALL cover: NUM_IN=20, in_sel=25 -> out_data=0; with MUX_PIPE_SEL_ERR_EN defined, sel_err=1 in the same cycle.
REQ-033 SHALL cover: reset_n pulsed low with 3 items in flight -> out_valid=0 immediately, no output after release, in_ready=1.
REQ-034 SHALL cover: NUM_IN=2, WIDTH=8 -> LAT=1, in_sel=1 selects channel 1 with 1-cycle latency.

Source files
------------

// File: rtl/mux_pipe_nto1.sv
// Pipelined N:1 mux built from registered 4:1 levels with valid/ready flow.
// Optional `MUX_PIPE_SEL_ERR_EN adds sel_err for out-of-range selects.
module mux_pipe_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [$clog2(NUM_IN)-1:0] in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0] out_sel,
    output logic                    out_valid,
`ifdef MUX_PIPE_SEL_ERR_EN
    output logic                    sel_err,
`endif
    input  logic                    out_ready
);

    localparam int SELW = $clog2(NUM_IN);
    localparam int LAT  = (SELW + 1) / 2;
    localparam int NPAD = 1 << SELW;

    logic [NPAD*WIDTH-1:0] leaves;
    logic [LAT-1:0]        vld;
    logic [LAT:0]          adv;

    // Pad the channel vector up to a power of two; missing leaves read 0
    always_comb begin
        leaves = '0;
        leaves[NUM_IN*WIDTH-1:0] = in_data;
    end

    // A level may load when it is empty or the level after it moves on
    always_comb begin
        adv = '0;
        adv[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            adv[k] = !vld[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    genvar k;
    for (k = 0; k < LAT; k++) begin : g_lvl
        localparam int NB   = (SELW - 2*k >= 2) ? 2 : 1;
        localparam int NIN  = 1 << (SELW - 2*k);
        localparam int NOUT = NIN >> NB;

        logic [NIN*WIDTH-1:0]  src;
        logic [SELW-1:0]       src_sel;
        logic                  src_vld;
        logic [NB-1:0]         pick;
        logic [NOUT*WIDTH-1:0] red;
        logic [NOUT*WIDTH-1:0] dq;
        logic [SELW-1:0]       sq;
        logic                  vq;

        if (k == 0) begin : g_first
            assign src     = leaves;
            assign src_sel = in_sel;
            assign src_vld = in_valid;
        end else begin : g_next
            assign src     = g_lvl[k-1].dq;
            assign src_sel = g_lvl[k-1].sq;
            assign src_vld = g_lvl[k-1].vq;
        end

        assign pick   = src_sel[2*k +: NB];
        assign vld[k] = vq;

        // Each output node picks one of its 2 or 4 children by this level's select bits
        always_comb begin
            red = '0;
            for (int j = 0; j < NOUT; j++) begin
                red[j*WIDTH +: WIDTH] =
                    src[((j << NB) + int'(pick))*WIDTH +: WIDTH];
            end
        end

        // Level register: capture only real items, keep contents across bubbles
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vq <= 1'b0;
                sq <= '0;
                dq <= '0;
            end else if (adv[k]) begin
                vq <= src_vld;
                if (src_vld) begin
                    sq <= src_sel;
                    dq <= red;
                end
            end
        end
    end

    assign out_data  = g_lvl[LAT-1].dq;
    assign out_sel   = g_lvl[LAT-1].sq;
    assign out_valid = g_lvl[LAT-1].vq;

`ifdef MUX_PIPE_SEL_ERR_EN
    assign sel_err = out_valid && (int'(out_sel) >= NUM_IN);
`endif

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Randomized bench for mux_pipe_nto1 against a queue-based reference model.
// Covers NUM_IN=32/W=32, NUM_IN=20/W=32 and NUM_IN=2/W=8 in parallel.
module tb_mux_pipe_nto1;

    localparam int N32 = 32, W32 = 32, S32 = 5, L32 = 3;
    localparam int N20 = 20, W20 = 32, S20 = 5, L20 = 3;
    localparam int N2  = 2,  W2  = 8,  S2  = 1, L2  = 1;

    typedef struct {
        logic [63:0] d;
        logic [63:0] s;
        int          rdy;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    int   lat;

    item_t q [3][$];

    logic [N32*W32-1:0] d32;
    logic [S32-1:0]     s32, os32;
    logic               v32, ir32, ov32, or32;
    logic [W32-1:0]     od32;

    logic [N20*W20-1:0] d20;
    logic [S20-1:0]     s20, os20;
    logic               v20, ir20, ov20, or20;
    logic [W20-1:0]     od20;
`ifdef MUX_PIPE_SEL_ERR_EN
    logic               err20;
`endif

    logic [N2*W2-1:0]   d2;
    logic [S2-1:0]      s2, os2;
    logic               v2, ir2, ov2, or2;
    logic [W2-1:0]      od2;

    logic [63:0] p32, p20, p2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mux_pipe_nto1 #(.WIDTH(W32), .NUM_IN(N32)) u32 (
        .clock(clk), .reset_n(rst_n),
        .in_data(d32), .in_sel(s32), .in_valid(v32), .in_ready(ir32),
        .out_data(od32), .out_sel(os32), .out_valid(ov32),
        .out_ready(or32)
    );

    mux_pipe_nto1 #(.WIDTH(W20), .NUM_IN(N20)) u20 (
        .clock(clk), .reset_n(rst_n),
        .in_data(d20), .in_sel(s20), .in_valid(v20), .in_ready(ir20),
        .out_data(od20), .out_sel(os20), .out_valid(ov20),
`ifdef MUX_PIPE_SEL_ERR_EN
        .sel_err(err20),
`endif
        .out_ready(or20)
    );

    mux_pipe_nto1 #(.WIDTH(W2), .NUM_IN(N2)) u2 (
        .clock(clk), .reset_n(rst_n),
        .in_data(d2), .in_sel(s2), .in_valid(v2), .in_ready(ir2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2),
        .out_ready(or2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Items leave in order, no earlier than LAT cycles after acceptance and
    // at most one per cycle; the pipe accepts while it holds fewer than LAT
    // items or the consumer is taking one this cycle.
    task automatic model_step(input int id, input int nl,
                              input logic ov, input logic [63:0] od,
                              input logic [63:0] os, input logic ir,
                              input logic iv, input logic [63:0] isel,
                              input logic [63:0] ipick, input logic ordy);
        bit    ev, eir;
        item_t it;
        ev = (q[id].size() > 0) && (q[id][0].rdy <= cyc);
        chk($sformatf("ovalid%0d", id), {63'd0, ov}, {63'd0, ev});
        if (ev) begin
            chk($sformatf("odata%0d", id), od, q[id][0].d);
            chk($sformatf("osel%0d", id), os, q[id][0].s);
        end
        eir = (q[id].size() < nl) || ordy;
        chk($sformatf("iready%0d", id), {63'd0, ir}, {63'd0, eir});
        if (ev && ordy) begin
            void'(q[id].pop_front());
            if (q[id].size() > 0) begin
                it = q[id].pop_front();
                if (it.rdy < cyc + 1) it.rdy = cyc + 1;
                q[id].push_front(it);
            end
        end
        if (iv && eir) begin
            it.d = ipick;
            it.s = isel;
            it.rdy = cyc + nl;
            q[id].push_back(it);
        end
    endtask

    // Reference model runs on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ov32", {63'd0, ov32}, 64'd0);
            chk("rst_od32", {32'd0, od32}, 64'd0);
            chk("rst_os32", {59'd0, os32}, 64'd0);
            chk("rst_ov20", {63'd0, ov20}, 64'd0);
            chk("rst_ov2", {63'd0, ov2}, 64'd0);
            for (int i = 0; i < 3; i++) q[i].delete();
        end else begin
            p32 = (int'(s32) < N32) ? 64'(d32[int'(s32)*W32 +: W32]) : 64'd0;
            p20 = (int'(s20) < N20) ? 64'(d20[int'(s20)*W20 +: W20]) : 64'd0;
            p2  = (int'(s2) < N2) ? 64'(d2[int'(s2)*W2 +: W2]) : 64'd0;
`ifdef MUX_PIPE_SEL_ERR_EN
            if (q[1].size() > 0 && q[1][0].rdy <= cyc)
                chk("selerr20", {63'd0, err20}, {63'd0, q[1][0].s >= N20});
            else
                chk("selerr20", {63'd0, err20}, 64'd0);
`endif
            model_step(0, L32, ov32, 64'(od32), 64'(os32), ir32,
                       v32, 64'(s32), p32, or32);
            model_step(1, L20, ov20, 64'(od20), 64'(os20), ir20,
                       v20, 64'(s20), p20, or20);
            model_step(2, L2, ov2, 64'(od2), 64'(os2), ir2,
                       v2, 64'(s2), p2, or2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v32 = 1'b0; v20 = 1'b0; v2 = 1'b0;
        or32 = 1'b1; or20 = 1'b1; or2 = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N32; i++) d32[i*W32 +: W32] = 32'hA000_0000 + i;
        for (int i = 0; i < N20; i++) d20[i*W20 +: W20] = $urandom;
        for (int i = 0; i < N2; i++) d2[i*W2 +: W2] = 8'($urandom);
        s32 = '0; s20 = '0; s2 = '0;
        idle_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ir_after_rst", {63'd0, ir32}, 64'd1);
        tick();

        // Single item: 3-cycle latency on the 32-way mux
        v32 = 1'b1; s32 = 5'd5;
        v2 = 1'b1; s2 = 1'b1;
        v20 = 1'b1; s20 = 5'd25;
        tick();
        idle_all();
        lat = 1;
        while (!ov32 && lat < 8) begin tick(); lat++; end
        chk("lat32", 64'(lat), 64'd3);
        chk("d32_sel5", 64'(od32), 64'hA000_0005);
        repeat (4) tick();

        // Back-to-back stream of every channel
        for (int i = 0; i < N32; i++) begin
            v32 = 1'b1; s32 = 5'(i);
            tick();
        end
        idle_all();
        repeat (5) tick();

        // Consumer stalls for 10 cycles while the producer keeps pushing
        or32 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v32 = 1'b1; s32 = 5'(i + 7);
            tick();
        end
        chk("stall_ir", {63'd0, ir32}, 64'd0);
        or32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s32 = 5'(i + 20);
            tick();
        end
        idle_all();
        repeat (5) tick();

        // Randomized traffic on all three instances
        for (int n = 0; n < 400; n++) begin
            v32 = 1'($urandom_range(0, 1));
            s32 = 5'($urandom_range(0, 31));
            or32 = ($urandom_range(0, 3) != 0);
            v20 = 1'($urandom_range(0, 1));
            s20 = 5'($urandom_range(0, 31));
            or20 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N20; i++) d20[i*W20 +: W20] = $urandom;
            v2 = ($urandom_range(0, 3) != 0);
            s2 = 1'($urandom_range(0, 1));
            or2 = 1'($urandom_range(0, 1));
            d2 = 16'($urandom);
            tick();
        end
        idle_all();
        repeat (5) tick();

        // Reset with three items in flight
        or32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v32 = 1'b1; s32 = 5'(i + 1);
            tick();
        end
        v32 = 1'b0;
        tick();
        chk("pre_rst_ov", {63'd0, ov32}, 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rst_async_ov", {63'd0, ov32}, 64'd0);
        idle_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_ir", {63'd0, ir32}, 64'd1);
        repeat (6) begin
            tick();
            chk("no_ghost", {63'd0, ov32}, 64'd0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
